bus_fabric_n: RTL
=================

// Module: bus_fabric_n
// PURPOSE
//  Parametrised picorv32 native-bus interconnect: N slaves, programmable base/mask decode.
//  Per-slave select, ready qualification and rdata mux, plus a bus-error responder.
//  Unmapped addresses and slave timeouts end with an error response, so the core never hangs.
//  Sits between the picorv32 core and all SoC slaves (sram, leds, uart_wrap, countdown_timer).
// PARAMETERS
//  NSLAVES   4             number of slave ports (1..16)
//  SLV_BASE  {N{32'h0}}    packed N*32; slice i = base address of slave i
//  SLV_MASK  {N{32'h0}}    packed N*32; slice i = address compare mask of slave i
//  TIMEOUT   255           cycles in WAIT before error; 0 disables timeout; < 2**TO_WIDTH
//  TO_WIDTH  8             timeout counter width
//  ERR_DATA  32'hDEADBEEF  rdata returned on an error response
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  mem_valid   in   1         core request valid
//  mem_addr    in   32        core address
//  mem_ready   out  1         to core; transfer complete
//  mem_rdata   out  32        to core; read data
//  slv_sel     out  NSLAVES   one-hot select; bit i drives SLAVE_sel of slave i
//  slv_ready   in   NSLAVES   per-slave ready
//  slv_rdata   in   NSLAVES*32  packed slave read data; slice i belongs to slave i
//  err_pulse   out  1         1-cycle pulse on every error response
//  err_addr    out  32        mem_addr of the most recent error
//  err_count   out  16        saturating count of error responses
// BEHAVIOUR
//  Routing: mem_wdata and mem_wstrb go to the slaves directly and do not pass through this block.
//  Decode (combinational): match[i] = (mem_addr & SLV_MASK[i]) == SLV_BASE[i].
//   On overlapping matches, the lowest index wins. hit = |match.
//  slv_sel = onehot(match) when mem_valid && state!=ERR_RESP, else 0.
//  Ready qualification: only slv_ready[k] of the selected slave k is honoured.
//   A ready from any unselected slave is ignored.
//  FSM states: IDLE, WAIT, ERR_RESP. Reset: IDLE, cnt=0, all outputs 0.
//  IDLE:
//   - !mem_valid: stay in IDLE.
//   - mem_valid && !hit: go to ERR_RESP. Error ready comes 1 cycle after valid.
//   - mem_valid && hit && slv_ready[k]: mem_ready=1 in the same cycle; stay in IDLE.
//   - mem_valid && hit && !slv_ready[k]: go to WAIT with cnt=0.
//  WAIT:
//   - slv_ready[k]: mem_ready=1 combinationally; go to IDLE.
//   - TIMEOUT!=0 && cnt==TIMEOUT-1 && !ready: go to ERR_RESP.
//   - otherwise: cnt<=cnt+1.
//   - !mem_valid (illegal for picorv32): go to IDLE with no error.
//  ERR_RESP (exactly 1 cycle):
//   - Outputs: mem_ready=1, mem_rdata=ERR_DATA, slv_sel=0, err_pulse=1.
//   - Registers: err_addr<=mem_addr; err_count<=err_count+1, saturating at 16'hFFFF.
//   - Next state: IDLE.
//  Timing: a timed-out request gets its error ready exactly TIMEOUT+1 cycles after the first valid cycle.
//  mem_rdata: slv_rdata slice k whenever mem_ready comes from slave k; ERR_DATA in ERR_RESP; else 32'h0.
//  mem_ready is never asserted without mem_valid.
//  A late slave ready after a timeout (sel already 0) is ignored.
//  Back-to-back: after mem_ready, a new valid in the next cycle is decoded from IDLE with no bubble.
//  Reset mid-transfer: the next cycle is IDLE, cnt=0, slv_sel=0, err_count=0, err_addr=0.
// TESTING
//  Setup: N=4, bases 0000_0000/8000_0000/8000_0008/8000_0010; masks FFFF_E000/FFFF_FFFF/FFFF_FFF8/FFFF_FFFF; TIMEOUT=4.
//  1. valid, addr 0000_0100, slv_ready[0]=1 same cycle, rdata0=12345678
//     -> slv_sel=0001, mem_ready that cycle, mem_rdata=12345678, no err.
//  2. valid, addr 8000_000C, slv_ready[2] 3 cycles later
//     -> slv_sel=0100 held 4 cycles, single mem_ready, err_count=0.
//  3. valid, addr 4000_0000 -> next cycle: mem_ready=1, rdata=DEADBEEF, err_pulse, err_addr=4000_0000, err_count=1.
//  4. valid, addr 8000_0010, slave never ready
//     -> error ready at cycle 5, then slv_sel=0; a late slv_ready[3] is ignored.
//  5. slv_ready[1]=1 while slave 0 is selected and busy -> no mem_ready until slv_ready[0].
//  6. reset=1 while in WAIT -> next cycle: IDLE, slv_sel=0, err_count=0; the next request decodes normally.

Source files
------------

// File: rtl/bus_fabric_n.sv
// picorv32 native-bus interconnect: base/mask decode to N slaves, ready qualification,
// rdata mux and an error responder for unmapped addresses and slave timeouts.
module bus_fabric_n #(
  parameter int unsigned             NSLAVES  = 4,
  parameter logic [NSLAVES*32-1:0]   SLV_BASE = '0,
  parameter logic [NSLAVES*32-1:0]   SLV_MASK = '0,
  parameter int unsigned             TIMEOUT  = 255,
  parameter int unsigned             TO_WIDTH = 8,
  parameter logic [31:0]             ERR_DATA = 32'hDEADBEEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    mem_valid_i,
  input  logic [31:0]             mem_addr_i,
  output logic                    mem_ready_o,
  output logic [31:0]             mem_rdata_o,
  output logic [NSLAVES-1:0]      slv_sel_o,
  input  logic [NSLAVES-1:0]      slv_ready_i,
  input  logic [NSLAVES*32-1:0]   slv_rdata_i,
  output logic                    err_pulse_o,
  output logic [31:0]             err_addr_o,
  output logic [15:0]             err_count_o
);

  typedef enum logic [1:0] {StIdle, StWait, StErrResp} state_e;

  localparam logic [TO_WIDTH-1:0] CntLast = TO_WIDTH'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [15:0]         err_count_q, err_count_d;

  logic [NSLAVES-1:0]  match;
  logic [NSLAVES-1:0]  sel_onehot;
  logic [NSLAVES-1:0]  slv_sel;
  logic                hit;
  logic                sel_ready;
  logic [31:0]         sel_rdata;

  // Lowest-index match wins when regions overlap.
  always_comb begin
    logic found;
    found      = 1'b0;
    match      = '0;
    sel_onehot = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      match[i]      = (mem_addr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32];
      sel_onehot[i] = match[i] & ~found;
      found         = found | match[i];
    end
  end

  assign hit       = |match;
  assign slv_sel   = (mem_valid_i && (state_q != StErrResp)) ? sel_onehot : '0;
  assign sel_ready = |(slv_sel & slv_ready_i);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      if (slv_sel[i]) begin
        sel_rdata = sel_rdata | slv_rdata_i[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    mem_ready_o = 1'b0;
    mem_rdata_o = '0;
    err_pulse_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_i) begin
          if (!hit) begin
            state_d = StErrResp;
          end else if (sel_ready) begin
            mem_ready_o = 1'b1;
            mem_rdata_o = sel_rdata;
          end else begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
      end
      StWait: begin
        if (!mem_valid_i) begin
          // Master abandoned the request; return quietly.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (sel_ready) begin
          mem_ready_o = 1'b1;
          mem_rdata_o = sel_rdata;
          state_d     = StIdle;
          cnt_d       = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          state_d = StErrResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      StErrResp: begin
        mem_ready_o = mem_valid_i;
        mem_rdata_o = ERR_DATA;
        err_pulse_o = 1'b1;
        err_addr_d  = mem_addr_i;
        if (err_count_q != 16'hFFFF) begin
          err_count_d = err_count_q + 16'd1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign slv_sel_o   = slv_sel;
  assign err_addr_o  = err_addr_q;
  assign err_count_o = err_count_q;

endmodule
